mhz1_cycle_stretch: RTL



---
 rtl/mhz1_cycle_stretch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mhz1_cycle_stretch.sv
// -----------------------------------------------------------------------------
// mhz1_cycle_stretch
//
// Turns the address decoder's combinational 1 MHz-region select into a timed
// bus cycle for the slow peripherals (CRTC, ACIA, serial ULA, VIAs, ADC,
// FRED/JIM).
//
// A free-running divider produces the 2 MHz CPU cycle-end enable and the
// 1 MHz peripheral enable. If a CPU cycle addresses a 1 MHz peripheral, the
// cycle end is withheld until the next 1 MHz phase. The peripheral may then
// ask for more 1 MHz periods, up to a bounded number. Exactly one access
// strobe is issued per access, and read data is captured when the access
// completes.
//
// Ports
//   clk_16M00      in   system clock
//   reset_n        in   asynchronous, active-low reset
//   mhz1_enable    in   decoder select for the current CPU address
//   cpu_rnw        in   CPU read/not-write for the current cycle
//   periph_din     in   [7:0] read data from the selected peripheral
//   periph_wait    in   peripheral requests one more 1 MHz period
//   cpu_clken      out  one-clock CPU cycle-end enable (2 MHz nominal)
//   mhz1_clken     out  one-clock 1 MHz enable, free-running
//   periph_strobe  out  one-clock access strobe, on the completion clock
//   read_data      out  [7:0] captured read data, held until the next read
//   read_valid     out  one-clock pulse when read_data is being updated
//   stretching     out  high while the CPU cycle is being stretched
//   timeout        out  sticky flag, set when the wait budget runs out
// -----------------------------------------------------------------------------
module mhz1_cycle_stretch #(
   parameter int CLK_DIV  = 16,   // system clocks per 1 MHz period (power of two, >= 8)
   parameter int MAX_WAIT = 4     // extra 1 MHz periods granted to periph_wait
) (
   input  logic       clk_16M00,
   input  logic       reset_n,
   input  logic       mhz1_enable,
   input  logic       cpu_rnw,
   input  logic [7:0] periph_din,
   input  logic       periph_wait,
   output logic       cpu_clken,
   output logic       mhz1_clken,
   output logic       periph_strobe,
   output logic [7:0] read_data,
   output logic       read_valid,
   output logic       stretching,
   output logic       timeout
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int HALF_W = DIV_W - 1;
   localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STRETCH = 2'd1,
      EXTEND  = 2'd2
   } state_t;

   logic [DIV_W-1:0]  div_cnt_reg;
   state_t            state_reg,     state_next;
   logic [WAIT_W-1:0] wait_cnt_reg,  wait_cnt_next;
   logic              rnw_reg,       rnw_next;
   logic [7:0]        read_data_reg, read_data_next;
   logic              timeout_reg,   timeout_next;

   logic at_b;       // 2 MHz cycle boundary (mid-period and end of period)
   logic at_p;       // 1 MHz phase (last clock of the 1 MHz period)
   logic complete;   // this clock ends the stretched access
   logic forced;     // completion caused by running out of wait budget

   // The divider is a power of two, so natural wrap gives CLK_DIV-1 -> 0.
   assign at_b = &div_cnt_reg[HALF_W-1:0];
   assign at_p = &div_cnt_reg;

   assign mhz1_clken = at_p;
   assign stretching = (state_reg != IDLE);
   assign read_data  = read_data_reg;
   assign timeout    = timeout_reg;

   always_ff @(posedge clk_16M00 or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_reg   <= '0;
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         rnw_reg       <= 1'b0;
         read_data_reg <= 8'h00;
         timeout_reg   <= 1'b0;
      end else begin
         div_cnt_reg   <= div_cnt_reg + 1'b1;
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         rnw_reg       <= rnw_next;
         read_data_reg <= read_data_next;
         timeout_reg   <= timeout_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      wait_cnt_next  = wait_cnt_reg;
      rnw_next       = rnw_reg;
      read_data_next = read_data_reg;
      timeout_next   = timeout_reg;
      cpu_clken      = 1'b0;
      periph_strobe  = 1'b0;
      read_valid     = 1'b0;
      complete       = 1'b0;
      forced         = 1'b0;

      case (state_reg)
         IDLE: begin
            // The select only matters at a cycle boundary; the CPU holds
            // its bus while stalled, so direction is latched here once.
            if (at_b) begin
               if (mhz1_enable) begin
                  state_next    = STRETCH;
                  wait_cnt_next = '0;
                  rnw_next      = cpu_rnw;
               end else begin
                  cpu_clken = 1'b1;
               end
            end
         end

         STRETCH: begin
            // Entry happens on the clock before, so the first at_p seen
            // here is always the next phase after detection.
            if (at_p) begin
               if (periph_wait) begin
                  state_next = EXTEND;
               end else begin
                  complete = 1'b1;
               end
            end
         end

         EXTEND: begin
            if (at_p) begin
               if (!periph_wait) begin
                  complete = 1'b1;
               end else if (wait_cnt_reg < WAIT_LAST) begin
                  wait_cnt_next = wait_cnt_reg + 1'b1;
               end else begin
                  complete = 1'b1;
                  forced   = 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (complete) begin
         cpu_clken     = 1'b1;
         periph_strobe = 1'b1;
         state_next    = IDLE;
         if (rnw_reg) begin
            read_valid     = 1'b1;
            // A peripheral that never answered reads as an open bus.
            read_data_next = forced ? 8'hFF : periph_din;
         end
         if (forced) begin
            timeout_next = 1'b1;
         end
      end
   end

endmodule
